// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the hazard/forwarding scoreboard.
//   stage_rec_t : one in-flight instruction record held per pipeline stage
//   FWD_RF      : forwarding select value meaning "use the register-file value"
//   produces()  : true when a record will write a given (non-x0) register
// Register-address fields are stored at RA_MAX_W bits so one struct type
// serves every RA_W the top is built with (RA_W must be <= RA_MAX_W).
package hazard_pkg;

  localparam int RA_MAX_W = 8;
  localparam int FWD_RF   = 0;

  typedef struct packed {
    logic                valid;
    logic [RA_MAX_W-1:0] rd;
    logic                reg_write;
    logic                mem_read;
    logic [RA_MAX_W-1:0] rs1;
    logic [RA_MAX_W-1:0] rs2;
    logic                use_rs1;
    logic                use_rs2;
  } stage_rec_t;

  // x0 is hard-wired to zero, so nothing ever produces it.
  function automatic logic produces(stage_rec_t rec, logic [RA_MAX_W-1:0] r);
    return rec.valid && rec.reg_write && (rec.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_priority_sel.sv
// fwd_priority_sel: nearest-producer priority search over stages FIRST..LAST.
//   recs     in  stage records, index 1 = EX ... DEPTH = WB
//   src      in  source register being looked up
//   use_src  in  source is actually read (otherwise no match)
//   sel      out lowest stage index in FIRST..LAST producing src, else FWD_RF
//   sel_load out the selected producer is a load
// The lowest index is the youngest instruction, so it wins over older writers.
module fwd_priority_sel
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int RA_W  = 5,
  parameter int FIRST = 2,
  parameter int LAST  = DEPTH,
  localparam int SEL_W = $clog2(DEPTH + 1)
) (
  input  stage_rec_t        recs [1:DEPTH],
  input  logic [RA_W-1:0]   src,
  input  logic              use_src,
  output logic [SEL_W-1:0]  sel,
  output logic              sel_load
);

  logic [RA_MAX_W-1:0] src_ext;

  assign src_ext = RA_MAX_W'(src);

  always_comb begin
    sel      = SEL_W'(FWD_RF);
    sel_load = 1'b0;
    // Walk from the oldest stage down so the youngest match is written last.
    for (int k = LAST; k >= FIRST; k--) begin
      if (use_src && produces(recs[k], src_ext)) begin
        sel      = SEL_W'(k);
        sel_load = recs[k].mem_read;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard and forwarding controller for the in-order pipeline.
// Tracks every in-flight destination from EX (stage 1) to WB (stage DEPTH) in a
// registered shadow pipeline and derives stall / flush / freeze / forwarding.
//   clk, rst_n                clock, async active-low reset
//   id_*                      instruction currently in ID
//   ex_redirect               taken branch/jump resolved in EX
//   mem_busy                  data memory not ready; whole pipeline freezes
//   pc_en, if_id_en           front-end enables
//   if_id_flush, id_ex_bubble squash IF/ID, insert bubble into ID/EX
//   fwd_a_sel, fwd_b_sel      EX operand source (0 = RF, k = stage k result)
//   stall_cnt, flush_cnt      saturating event counters
// All control outputs are combinational from the current records and ID inputs.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 3,
  parameter int RA_W       = 5,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_rec_t recs [1:DEPTH];
  stage_rec_t id_rec;

  logic [SEL_W-1:0] stall_a_sel, stall_b_sel;
  logic             stall_a_load, stall_b_load;
  logic             fwd_a_load, fwd_b_load;
  logic             stall;
  logic             redirect;

  always_comb begin
    id_rec           = '0;
    id_rec.valid     = id_valid;
    id_rec.rd        = RA_MAX_W'(id_rd);
    id_rec.reg_write = id_reg_write;
    id_rec.mem_read  = id_mem_read;
    id_rec.rs1       = RA_MAX_W'(id_rs1);
    id_rec.rs2       = RA_MAX_W'(id_rs2);
    id_rec.use_rs1   = id_use_rs1;
    id_rec.use_rs2   = id_use_rs2;
  end

  // Load-use search: only stages 1..LOAD_READY-2 can hold a load whose data
  // will not yet be available when the ID instruction reaches EX. A younger
  // non-load producer in that window wins the priority and shadows the load.
  fwd_priority_sel #(
    .DEPTH(DEPTH), .RA_W(RA_W), .FIRST(1), .LAST(LOAD_READY - 2)
  ) u_stall_a (
    .recs(recs), .src(id_rs1), .use_src(id_valid & id_use_rs1),
    .sel(stall_a_sel), .sel_load(stall_a_load)
  );

  fwd_priority_sel #(
    .DEPTH(DEPTH), .RA_W(RA_W), .FIRST(1), .LAST(LOAD_READY - 2)
  ) u_stall_b (
    .recs(recs), .src(id_rs2), .use_src(id_valid & id_use_rs2),
    .sel(stall_b_sel), .sel_load(stall_b_load)
  );

  // EX-operand forwarding for the instruction sitting in stage 1.
  fwd_priority_sel #(
    .DEPTH(DEPTH), .RA_W(RA_W), .FIRST(2), .LAST(DEPTH)
  ) u_fwd_a (
    .recs(recs), .src(recs[1].rs1[RA_W-1:0]),
    .use_src(recs[1].valid & recs[1].use_rs1),
    .sel(fwd_a_sel), .sel_load(fwd_a_load)
  );

  fwd_priority_sel #(
    .DEPTH(DEPTH), .RA_W(RA_W), .FIRST(2), .LAST(DEPTH)
  ) u_fwd_b (
    .recs(recs), .src(recs[1].rs2[RA_W-1:0]),
    .use_src(recs[1].valid & recs[1].use_rs2),
    .sel(fwd_b_sel), .sel_load(fwd_b_load)
  );

  assign stall    = stall_a_load | stall_b_load;
  assign redirect = ex_redirect & ~mem_busy;

  // Redirect beats stall: the PC must load the branch target even if the
  // (wrong-path) ID instruction had a load-use hazard.
  assign pc_en        = ~mem_busy & (~stall | redirect);
  assign if_id_en     = pc_en;
  assign if_id_flush  = redirect;
  assign id_ex_bubble = (stall | redirect) & ~mem_busy;

  // Shadow pipeline: shifts one stage per cycle, frozen by mem_busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        recs[k] <= '0;
      end
    end else if (!mem_busy) begin
      recs[1] <= id_ex_bubble ? '0 : id_rec;
      for (int k = 2; k <= DEPTH; k++) begin
        recs[k] <= recs[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !redirect && !mem_busy && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (redirect && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: drives three scoreboard configurations from one shared
// instruction stream and checks every output, every cycle, against a
// behavioural model of in-flight instructions, plus directed literal checks.
//   inst 0: DEPTH=3 LOAD_READY=3 CNT_W=32 (defaults)
//   inst 1: DEPTH=5 LOAD_READY=4 CNT_W=32
//   inst 2: DEPTH=3 LOAD_READY=3 CNT_W=4
module tb_hazard_scoreboard;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared inputs ----------------
  logic       id_valid = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic       id_use_rs1 = 0, id_use_rs2 = 0;
  logic       id_reg_write = 0, id_mem_read = 0;
  logic       ex_redirect = 0, mem_busy = 0;

  // ---------------- DUT outputs ----------------
  logic        pc_en_w [3];
  logic        if_id_en_w [3];
  logic        flush_w [3];
  logic        bubble_w [3];
  logic [1:0]  fa0, fb0, fa2, fb2;
  logic [2:0]  fa1, fb1;
  logic [31:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;
  logic [2:0]  fa_w [3];
  logic [2:0]  fb_w [3];
  logic [31:0] sc_w [3];
  logic [31:0] fc_w [3];

  assign fa_w[0] = {1'b0, fa0};
  assign fb_w[0] = {1'b0, fb0};
  assign fa_w[1] = fa1;
  assign fb_w[1] = fb1;
  assign fa_w[2] = {1'b0, fa2};
  assign fb_w[2] = {1'b0, fb2};
  assign sc_w[0] = sc0;
  assign fc_w[0] = fc0;
  assign sc_w[1] = sc1;
  assign fc_w[1] = fc1;
  assign sc_w[2] = {28'd0, sc2};
  assign fc_w[2] = {28'd0, fc2};

  hazard_scoreboard u_dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_en(pc_en_w[0]), .if_id_en(if_id_en_w[0]), .if_id_flush(flush_w[0]),
    .id_ex_bubble(bubble_w[0]), .fwd_a_sel(fa0), .fwd_b_sel(fb0),
    .stall_cnt(sc0), .flush_cnt(fc0)
  );

  hazard_scoreboard #(.DEPTH(5), .LOAD_READY(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_en(pc_en_w[1]), .if_id_en(if_id_en_w[1]), .if_id_flush(flush_w[1]),
    .id_ex_bubble(bubble_w[1]), .fwd_a_sel(fa1), .fwd_b_sel(fb1),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  hazard_scoreboard #(.CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_en(pc_en_w[2]), .if_id_en(if_id_en_w[2]), .if_id_flush(flush_w[2]),
    .id_ex_bubble(bubble_w[2]), .fwd_a_sel(fa2), .fwd_b_sel(fb2),
    .stall_cnt(sc2), .flush_cnt(fc2)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per configuration: a list of in-flight instructions indexed by how many
  // stages past ID they are (1..depth); invalid slots are bubbles.
  int     dep  [3] = '{3, 5, 3};
  int     lr   [3] = '{3, 4, 3};
  longint cmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

  bit     mv  [3][7];
  int     mrd [3][7];
  bit     mrw [3][7];
  bit     mmr [3][7];
  int     mrs1[3][7];
  int     mrs2[3][7];
  bit     mu1 [3][7];
  bit     mu2 [3][7];
  longint mstall[3];
  longint mflush[3];

  // Youngest in-flight instruction in stages lo..hi that writes register r.
  function automatic int nearest(int i, int r, int lo, int hi);
    for (int k = lo; k <= hi; k++) begin
      if (mv[i][k] && mrw[i][k] && mrd[i][k] == r && r != 0) return k;
    end
    return 0;
  endfunction

  // A used source needs a stall when its youngest producer is a load that
  // will not have data by the time this instruction is in EX.
  function automatic bit src_stalls(int i, int r);
    int j;
    j = nearest(i, r, 1, dep[i]);
    return (j != 0) && mmr[i][j] && (j <= lr[i] - 2);
  endfunction

  function automatic bit m_stall(int i);
    bit s;
    s = 0;
    if (id_valid && id_use_rs1 && src_stalls(i, int'(id_rs1))) s = 1;
    if (id_valid && id_use_rs2 && src_stalls(i, int'(id_rs2))) s = 1;
    return s;
  endfunction

  function automatic int m_fwd(int i, bit use_it, int r);
    if (!mv[i][1] || !use_it) return 0;
    return nearest(i, r, 2, dep[i]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 7; k++) mv[i][k] <= 0;
        mstall[i] <= 0;
        mflush[i] <= 0;
      end
    end else if (!mem_busy) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 2; k <= dep[i]; k++) begin
          mv[i][k]   <= mv[i][k-1];
          mrd[i][k]  <= mrd[i][k-1];
          mrw[i][k]  <= mrw[i][k-1];
          mmr[i][k]  <= mmr[i][k-1];
          mrs1[i][k] <= mrs1[i][k-1];
          mrs2[i][k] <= mrs2[i][k-1];
          mu1[i][k]  <= mu1[i][k-1];
          mu2[i][k]  <= mu2[i][k-1];
        end
        mv[i][1]   <= id_valid && !m_stall(i) && !ex_redirect;
        mrd[i][1]  <= int'(id_rd);
        mrw[i][1]  <= id_reg_write;
        mmr[i][1]  <= id_mem_read;
        mrs1[i][1] <= int'(id_rs1);
        mrs2[i][1] <= int'(id_rs2);
        mu1[i][1]  <= id_use_rs1;
        mu2[i][1]  <= id_use_rs2;
        if (m_stall(i) && !ex_redirect && mstall[i] < cmax[i]) mstall[i] <= mstall[i] + 1;
        if (ex_redirect && mflush[i] < cmax[i]) mflush[i] <= mflush[i] + 1;
      end
    end
  end

  // Compare process: every falling edge, all outputs of all configurations.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit st, rd_q, e_pc, e_bub;
      st    = m_stall(i);
      rd_q  = ex_redirect && !mem_busy;
      e_pc  = !mem_busy && (!st || rd_q);
      e_bub = (st || rd_q) && !mem_busy;
      chk($sformatf("pc_en[%0d]", i), pc_en_w[i], e_pc);
      chk($sformatf("if_id_en[%0d]", i), if_id_en_w[i], e_pc);
      chk($sformatf("if_id_flush[%0d]", i), flush_w[i], rd_q);
      chk($sformatf("id_ex_bubble[%0d]", i), bubble_w[i], e_bub);
      chk($sformatf("fwd_a_sel[%0d]", i), fa_w[i], m_fwd(i, mu1[i][1], mrs1[i][1]));
      chk($sformatf("fwd_b_sel[%0d]", i), fb_w[i], m_fwd(i, mu2[i][1], mrs2[i][1]));
      chk($sformatf("stall_cnt[%0d]", i), sc_w[i], mstall[i]);
      chk($sformatf("flush_cnt[%0d]", i), fc_w[i], mflush[i]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit v, input int rs1, input bit u1, input int rs2,
                        input bit u2, input int rd, input bit rw, input bit mr,
                        input bit redir = 0, input bit busy = 0);
    id_valid     = v;
    id_rs1       = 5'(rs1);
    id_use_rs1   = u1;
    id_rs2       = 5'(rs2);
    id_use_rs2   = u2;
    id_rd        = 5'(rd);
    id_reg_write = rw;
    id_mem_read  = mr;
    ex_redirect  = redir;
    mem_busy     = busy;
  endtask

  task automatic nop(input bit redir = 0, input bit busy = 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, redir, busy);
  endtask

  // lw rd, 0(x0)
  task automatic lw(input int rd);
    set_in(1, 0, 0, 0, 0, rd, 1, 0 | 1);
  endtask

  // alu rd, rs1, rs2
  task automatic alu(input int rd, input int rs1, input int rs2,
                     input bit redir = 0, input bit busy = 0);
    set_in(1, rs1, 1, rs2, 1, rd, 1, 0, redir, busy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves time at posedge+1 with records empty and counters zero.
  task automatic do_reset();
    nop();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    tick();
    do_reset();

    // Reset state.
    #2;
    chk("rst_pc_en", pc_en_w[0], 1);
    chk("rst_if_id_en", if_id_en_w[0], 1);
    chk("rst_fwd_a", fa0, 0);
    chk("rst_fwd_b", fb0, 0);
    chk("rst_stall_cnt", sc0, 0);
    chk("rst_flush_cnt", fc0, 0);
    tick();

    // lw x5 ; add x6,x5,x7 (add re-presented while the front end is held).
    lw(5);
    #2 chk("lu_a_pc_en", pc_en_w[0], 1);
    tick();
    alu(6, 5, 7);
    #2;
    chk("lu_b_pc_en0", pc_en_w[0], 0);
    chk("lu_b_bubble0", bubble_w[0], 1);
    chk("lu_b_pc_en1", pc_en_w[1], 0);
    tick();
    alu(6, 5, 7);
    #2;
    chk("lu_c_pc_en0", pc_en_w[0], 1);
    chk("lu_c_pc_en1", pc_en_w[1], 0);
    tick();
    alu(6, 5, 7);
    #2;
    chk("lu_d_fwd_a0", fa0, 3);
    chk("lu_d_stall_cnt0", sc0, 1);
    chk("lu_d_pc_en1", pc_en_w[1], 1);
    chk("lu_d_stall_cnt1", sc1, 2);
    tick();
    nop();
    #2;
    chk("lu_e_fwd_a1", fa1, 4);
    // Reset in mid-stream discards records and counters at once.
    rst_n = 1'b0;
    #1;
    chk("midrst_stall_cnt1", sc1, 0);
    chk("midrst_fwd_a1", fa1, 0);
    chk("midrst_pc_en1", pc_en_w[1], 1);
    tick();
    rst_n = 1'b1;
    tick();

    // add x5 ; sub x8,x5,x5 -> forward from stage 2, no stall.
    do_reset();
    alu(5, 1, 2);
    tick();
    alu(8, 5, 5);
    #2 chk("alu_b_pc_en0", pc_en_w[0], 1);
    tick();
    nop();
    #2;
    chk("alu_c_fwd_a0", fa0, 2);
    chk("alu_c_fwd_b0", fb0, 2);
    chk("alu_c_fwd_a1", fa1, 2);
    tick();

    // Same with x0 as destination -> never forwarded.
    do_reset();
    alu(0, 1, 2);
    tick();
    alu(8, 0, 0);
    tick();
    nop();
    #2;
    chk("x0_fwd_a0", fa0, 0);
    chk("x0_fwd_b0", fb0, 0);
    tick();

    // Deep config: lw x3 ; nop ; dependent -> one stall cycle.
    do_reset();
    lw(3);
    tick();
    nop();
    tick();
    alu(9, 3, 0);
    #2;
    chk("gap_c_pc_en1", pc_en_w[1], 0);
    chk("gap_c_pc_en0", pc_en_w[0], 1);
    tick();
    alu(9, 3, 0);
    #2 chk("gap_d_pc_en1", pc_en_w[1], 1);
    tick();
    nop();
    #2;
    chk("gap_e_stall_cnt1", sc1, 1);
    chk("gap_e_fwd_a1", fa1, 4);
    tick();

    // Stall and redirect together: redirect wins.
    do_reset();
    lw(5);
    tick();
    alu(6, 5, 7, 1'b1);
    #2;
    chk("sr_pc_en0", pc_en_w[0], 1);
    chk("sr_flush0", flush_w[0], 1);
    chk("sr_bubble0", bubble_w[0], 1);
    tick();
    nop();
    #2;
    chk("sr_flush_cnt0", fc0, 1);
    chk("sr_stall_cnt0", sc0, 0);
    tick();

    // mem_busy for 4 cycles over a pending load-use (one with a redirect).
    do_reset();
    lw(5);
    tick();
    for (int c = 0; c < 4; c++) begin
      alu(6, 5, 7, (c == 2), 1'b1);
      #2;
      chk("busy_pc_en0", pc_en_w[0], 0);
      chk("busy_if_id_en0", if_id_en_w[0], 0);
      chk("busy_bubble0", bubble_w[0], 0);
      chk("busy_flush0", flush_w[0], 0);
      chk("busy_stall_cnt0", sc0, 0);
      chk("busy_flush_cnt0", fc0, 0);
      tick();
    end
    alu(6, 5, 7);
    #2;
    chk("post_busy_pc_en0", pc_en_w[0], 0);
    chk("post_busy_bubble0", bubble_w[0], 1);
    tick();
    alu(6, 5, 7);
    #2;
    chk("post_busy2_pc_en0", pc_en_w[0], 1);
    chk("post_busy2_stall_cnt0", sc0, 1);
    tick();
    nop();
    #2 chk("post_busy3_fwd_a0", fa0, 3);
    tick();

    // 20 redirects: 4-bit counter saturates at 15.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      nop(1'b1);
      tick();
    end
    nop();
    #2;
    chk("sat_flush_cnt2", fc2, 15);
    chk("sat_flush_cnt0", fc0, 20);
    chk("sat_flush_cnt1", fc1, 20);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
